// File: rtl/network_acc_pkg.sv
// Shared widths, saturation limits and datapath types for the conv accumulator / requantiser.
package network_acc_pkg;

    localparam int DEF_PROD_W = 26;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 8;

    typedef logic signed [DEF_PROD_W-1:0] prod_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;
    typedef logic signed [DEF_OUT_W-1:0]  act_t;

    localparam act_t OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam act_t OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/network_requant_sat.sv
// Round-half-up, arithmetic shift, optional ReLU and saturation of an accumulator value.
// Purely combinational; no handshake of its own.
module network_requant_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter bit RELU  = 1'b0
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] res,
    output logic             sat
);

    // Limits widened to ACC_W+1 so the comparison sees the full shifted value.
    localparam logic signed [ACC_W:0] HI = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] LO = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] relued;

    generate
        if (SHIFT > 0) begin : g_round
            assign rounded = {sum[ACC_W-1], sum} + ((ACC_W+1)'(1) << (SHIFT-1));
        end else begin : g_noround
            assign rounded = {sum[ACC_W-1], sum};
        end
    endgenerate

    assign shifted = rounded >>> SHIFT;

    always_comb begin
        relued = shifted;
        res    = shifted[OUT_W-1:0];
        sat    = 1'b0;
        if (RELU && (shifted < 0)) begin
            relued = '0;
        end
        res = relued[OUT_W-1:0];
        if (relued > HI) begin
            res = HI[OUT_W-1:0];
            sat = 1'b1;
        end else if (relued < LO) begin
            res = LO[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/network_acc_requant.sv
// Accumulates a window of signed products plus bias, then requantises to a saturated activation.
// Latency: one cycle from the accepted last beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls the whole input stream.
module network_acc_requant
    import network_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter bit RELU   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [OUT_W-1:0]  bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] bias_ext;
    logic             first;
    logic             accept;
    logic [OUT_W-1:0] rq_data;
    logic             rq_sat;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
    assign bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} << SHIFT;
    // The first beat of a window restarts from the bias instead of the old sum.
    assign acc_next = (first ? bias_ext : acc) + prod_ext;

    network_requant_sat #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .RELU (RELU)
    ) u_requant (
        .sum(acc_next),
        .res(rq_data),
        .sat(rq_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= acc_next;
                first <= in_last;
            end
            if (accept && in_last) begin
                out_valid <= 1'b1;
                out_data  <= rq_data;
                out_sat   <= rq_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_network_acc_requant.sv
// Bench for network_acc_requant: directed tables, corner sequences and a randomized run against a window-sum model.
module tb_network_acc_requant;
    import network_acc_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic [DEF_PROD_W-1:0] in_data;
    logic                  in_last;
    logic [DEF_OUT_W-1:0]  bias;
    logic                  out_ready;
    logic                  in_ready0, in_ready1;
    logic                  out_valid0, out_valid1;
    logic [DEF_OUT_W-1:0]  out_data0, out_data1;
    logic                  out_sat0, out_sat1;

    always #5 clk = ~clk;

    network_acc_requant #(.RELU(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    network_acc_requant #(.RELU(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: the exact window sum as a wide integer, plus the pending result.
    bit     m_first = 1'b1;
    bit     m_ov    = 1'b0;
    longint m_sum   = 0;
    longint m_od0   = 0;
    longint m_od1   = 0;
    bit     m_os0   = 1'b0;
    bit     m_os1   = 1'b0;

    typedef struct {
        int b;
        int p;
        int e0;
        bit s0;
        int e1;
        bit s1;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Window sum wrapped to 32 bits, then floor((s + 2^(SHIFT-1)) / 2^SHIFT), ReLU, clamp.
    function automatic void requant(input longint s, input bit relu, output longint d, output bit sat);
        longint n;
        longint dv;
        longint q;
        n  = longint'(int'(s)) + (longint'(1) << (DEF_SHIFT - 1));
        dv = longint'(1) << DEF_SHIFT;
        q  = n / dv;
        if ((n % dv != 0) && (n < 0)) q = q - 1;
        if (relu && q < 0) q = 0;
        sat = 1'b0;
        if (q > longint'(OUT_MAX)) begin
            q   = longint'(OUT_MAX);
            sat = 1'b1;
        end else if (q < longint'(OUT_MIN)) begin
            q   = longint'(OUT_MIN);
            sat = 1'b1;
        end
        d = q;
    endfunction

    // Called at posedge+1: drive, check ready, clock, then check outputs at posedge+1.
    task automatic step(input bit v, input int d, input bit last, input int b, input bit ordy);
        bit exp_rdy;
        in_valid  = v;
        in_data   = d[DEF_PROD_W-1:0];
        in_last   = last;
        bias      = b[DEF_OUT_W-1:0];
        out_ready = ordy;
        #1;
        exp_rdy = !m_ov || ordy;
        chk("in_ready", in_ready0, exp_rdy);
        chk("in_ready_relu", in_ready1, exp_rdy);
        @(posedge clk);
        if (v && exp_rdy) begin
            if (m_first) m_sum = longint'(b) * (longint'(1) << DEF_SHIFT) + longint'(d);
            else         m_sum = m_sum + longint'(d);
            m_first = last;
        end
        if (v && exp_rdy && last) begin
            requant(m_sum, 1'b0, m_od0, m_os0);
            requant(m_sum, 1'b1, m_od1, m_os1);
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", out_valid0, m_ov);
        chk("out_valid_relu", out_valid1, m_ov);
        chk("out_data", $signed(out_data0), m_od0);
        chk("out_data_relu", $signed(out_data1), m_od1);
        chk("out_sat", out_sat0, m_os0);
        chk("out_sat_relu", out_sat1, m_os1);
    endtask

    // Asynchronous reset assertion checked before any clock edge; released away from the edge.
    task automatic do_reset(input string nm);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk({nm, "_out_valid"}, out_valid0, 0);
        chk({nm, "_out_data"}, $signed(out_data0), 0);
        chk({nm, "_out_sat"}, out_sat0, 0);
        chk({nm, "_in_ready"}, in_ready0, 1);
        chk({nm, "_out_data_relu"}, $signed(out_data1), 0);
        m_first = 1'b1;
        m_ov    = 1'b0;
        m_od0   = 0;
        m_od1   = 0;
        m_os0   = 1'b0;
        m_os1   = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wl;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;

        tbl[0] = '{0, 383, 1, 1'b0, 1, 1'b0};
        tbl[1] = '{0, 384, 2, 1'b0, 2, 1'b0};
        tbl[2] = '{0, -384, -1, 1'b0, 0, 1'b0};
        tbl[3] = '{0, -385, -2, 1'b0, 0, 1'b0};
        tbl[4] = '{32767, 33554431, 32767, 1'b1, 32767, 1'b1};
        tbl[5] = '{-32768, -33554432, -32768, 1'b1, 0, 1'b0};
        tbl[6] = '{0, 512, 2, 1'b0, 2, 1'b0};
        tbl[7] = '{0, -128, 0, 1'b0, 0, 1'b0};
        tbl[8] = '{0, -129, -1, 1'b0, 0, 1'b0};
        tbl[9] = '{127, 0, 127, 1'b0, 127, 1'b0};

        #2;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", $signed(out_data0), 0);
        chk("rst_out_sat", out_sat0, 0);
        chk("rst_in_ready", in_ready0, 1);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-beat window: (1<<8) + 256 + 512 - 256 = 768 -> 3
        step(1'b1, 256, 1'b0, 1, 1'b1);
        step(1'b1, 512, 1'b0, 1, 1'b1);
        chk("basic_not_yet_valid", out_valid0, 0);
        step(1'b1, -256, 1'b1, 1, 1'b1);
        chk("basic_valid", out_valid0, 1);
        chk("basic_data", $signed(out_data0), 3);
        chk("basic_sat", out_sat0, 0);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].p, 1'b1, tbl[i].b, 1'b1);
            chk("tbl_data", $signed(out_data0), tbl[i].e0);
            chk("tbl_sat", out_sat0, tbl[i].s0);
            chk("tbl_data_relu", $signed(out_data1), tbl[i].e1);
            chk("tbl_sat_relu", out_sat1, tbl[i].s1);
        end

        // Held output freezes input, then a drain coincides with a new last beat.
        step(1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b1, 1024, 1'b1, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 777, 1'b0, 0, 1'b0);
            chk("hold_data", $signed(out_data0), 4);
            chk("hold_valid", out_valid0, 1);
        end
        step(1'b1, 512, 1'b1, 0, 1'b1);
        chk("b2b_valid", out_valid0, 1);
        chk("b2b_data", $signed(out_data0), 2);
        step(1'b1, 256, 1'b1, 0, 1'b1);
        chk("after_hold_data", $signed(out_data0), 1);

        // Reset while a result is held, then reset in the middle of a window.
        step(1'b0, 0, 1'b0, 0, 1'b0);
        do_reset("rst_held");
        step(1'b1, 1000, 1'b0, 0, 1'b1);
        step(1'b1, 1000, 1'b0, 0, 1'b1);
        do_reset("rst_mid");
        step(1'b1, 512, 1'b1, 0, 1'b1);
        chk("post_rst_data", $signed(out_data0), 2);
        chk("post_rst_valid", out_valid0, 1);

        wl = 0;
        for (int k = 0; k < 400; k++) begin
            bit v, last, ordy;
            int d, b;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 3) == 0) || (wl >= 50);
            b    = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 40000)) - 20000;
            else                           d = $signed($urandom) >>> 6;
            if (v && (!m_ov || ordy)) wl = last ? 0 : wl + 1;
            step(v, d, last, b, ordy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
